// File: rtl/div_by_sub.sv
// Unsigned divider using repeated subtraction, one subtraction per clock.
// Define DIV_BY_SUB_DBZ_EN to add the div_by_zero flag and an early exit on a zero divisor.
module div_by_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_BY_SUB_DBZ_EN
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] q_reg;
    logic             sub_ok;

    // Without the zero-divisor exit, a zero divisor keeps subtracting and Q wraps until reset.
`ifdef DIV_BY_SUB_DBZ_EN
    assign sub_ok = (r_reg >= b_reg) && (b_reg != '0);
`else
    assign sub_ok = (r_reg >= b_reg);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: next_state = SUB;
            SUB:  if (!sub_ok) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            LOAD, SUB: busy = 1'b1;
            DONE:      done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Results are written on the SUB->DONE edge so they are already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg       <= '0;
            b_reg       <= '0;
            q_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIV_BY_SUB_DBZ_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r_reg <= dividend;
                        b_reg <= divisor;
                        q_reg <= '0;
                    end
                end
                SUB: begin
                    if (sub_ok) begin
                        r_reg <= r_reg - b_reg;
                        q_reg <= q_reg + 1'b1;
                    end else begin
                        remainder <= r_reg;
`ifdef DIV_BY_SUB_DBZ_EN
                        if (b_reg == '0) begin
                            quotient    <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= q_reg;
                            div_by_zero <= 1'b0;
                        end
`else
                        quotient <= q_reg;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_by_sub.sv
// Self-checking bench for div_by_sub: directed runs with a scoreboard of expected results.
// Also exercises the DIV_BY_SUB_DBZ_EN build when that macro is defined.
module tb_div_by_sub;

    localparam int WIDTH = 16;
    localparam int LIMIT = 70000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef DIV_BY_SUB_DBZ_EN
    logic             div_by_zero;
`endif

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   busy_cnt  = 0;
    int   done_cnt  = 0;

    div_by_sub #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
`ifdef DIV_BY_SUB_DBZ_EN
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
`else
        .remainder  (remainder)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] dvd,
                                 input logic [WIDTH-1:0] dvs, input logic dbz);
        exp_t e;
        e.tag = tag;
        e.dbz = dbz;
        if (dbz) begin
            e.q   = '1;
            e.r   = dvd;
            e.lat = 3;
        end else begin
            e.q   = dvd / dvs;
            e.r   = dvd % dvs;
            e.lat = int'(e.q) + 3;
        end
        sb.push_back(e);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        cyc      = -1;
        busy_cnt = 0;
        done_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        while (done !== 1'b1 && cyc < LIMIT) tick();
        e = sb.pop_front();
        check({e.tag, "_latency"}, cyc + 1, e.lat);
        check({e.tag, "_quotient"}, quotient, e.q);
        check({e.tag, "_remainder"}, remainder, e.r);
        check({e.tag, "_busy_cycles"}, busy_cnt, e.lat - 1);
`ifdef DIV_BY_SUB_DBZ_EN
        check({e.tag, "_dbz"}, div_by_zero, e.dbz);
`endif
        tick();
        check({e.tag, "_done_pulse"}, done, 1'b0);
        check({e.tag, "_done_count"}, done_cnt, 1);
        check({e.tag, "_hold_q"}, quotient, e.q);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("d100_7", 16'd100, 16'd7, 1'b0);
        checkOutput();

        applyStimulus("d5_9", 16'd5, 16'd9, 1'b0);
        checkOutput();
        applyStimulus("d9_9", 16'd9, 16'd9, 1'b0);
        checkOutput();
        applyStimulus("d0_4", 16'd0, 16'd4, 1'b0);
        checkOutput();

        applyStimulus("d65535_1", 16'd65535, 16'd1, 1'b0);
        checkOutput();

        // A second start while busy, with new operands, must not disturb the first run.
        applyStimulus("d50_5", 16'd50, 16'd5, 1'b0);
        start    = 1'b1;
        dividend = 16'd8;
        divisor  = 16'd2;
        repeat (3) tick();
        start = 1'b0;
        checkOutput();
        repeat (4) tick();
        check("ignored_start_no_extra_done", done_cnt, 1);

        // Reset in the middle of SUB abandons the operation.
        applyStimulus("d1000_3", 16'd1000, 16'd3, 1'b0);
        repeat (20) tick();
        void'(sb.pop_front());
        rst = 1'b1;
        #1;
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (5) tick();
        check("midrst_no_done", done_cnt, 0);
        applyStimulus("d20_6", 16'd20, 16'd6, 1'b0);
        checkOutput();

`ifdef DIV_BY_SUB_DBZ_EN
        applyStimulus("d42_0", 16'd42, 16'd0, 1'b1);
        checkOutput();
        applyStimulus("d9_3", 16'd9, 16'd3, 1'b0);
        checkOutput();
`else
        // A zero divisor without the early exit never completes.
        start    = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd0;
        done_cnt = 0;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("dbz_stuck_busy", busy, 1'b1);
        check("dbz_stuck_no_done", done_cnt, 0);
        rst = 1'b1;
        #1;
        check("dbz_stuck_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("d9_3", 16'd9, 16'd3, 1'b0);
        checkOutput();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
